// File: rtl/cic_pkg.sv
// Shared constants and sizing helpers for the CIC decimator and its comb stages.
package cic_pkg;

    localparam int unsigned ORDER_MIN = 1;
    localparam int unsigned ORDER_MAX = 6;
    localparam int unsigned LOG2_MIN  = 1;
    localparam int unsigned SHIFT_W   = 8;

    // Internal width that holds the full CIC gain without loss.
    function automatic int unsigned reg_w(input int unsigned dw_i,
                                          input int unsigned order,
                                          input int unsigned max_log2);
        return dw_i + order * max_log2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb (differentiator) stage: y = x - x_delayed, advanced only on a valid token.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned REG_W = reg_w(12, 4, 6)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             valid_i,
    input  logic [REG_W-1:0] data_i,
    output logic             valid_o,
    output logic [REG_W-1:0] data_o
);

    logic [REG_W-1:0] dly_q;
    logic [REG_W-1:0] diff_q;
    logic [REG_W-1:0] diff_d;
    logic             valid_q;

    assign diff_d = data_i - dly_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dly_q   <= '0;
            diff_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                diff_q <= diff_d;
                dly_q  <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = diff_q;

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: ORDER integrators, 2^k decimation, ORDER comb stages, gain normalisation.
// Define CIC_DECIMATOR_ROUND_SAT_EN for round-half-up plus saturation instead of truncate/wrap.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_I = 12,
    parameter int unsigned DATA_WIDTH_O = 16,
    parameter int unsigned ORDER        = 4,
    parameter int unsigned MAX_LOG2     = 6,
    parameter int unsigned DEFAULT_LOG2 = 3
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH_I-1:0]         in_data,
    input  logic [$clog2(MAX_LOG2+1)-1:0]   ratio_log2,
    output logic                            out_valid,
    output logic [DATA_WIDTH_O-1:0]         out_data
);

    localparam int unsigned LOG2_W   = $clog2(MAX_LOG2 + 1);
    localparam int unsigned REG_W    = reg_w(DATA_WIDTH_I, ORDER, MAX_LOG2);
    localparam int unsigned CNT_W    = MAX_LOG2;
    localparam int unsigned CW1      = CNT_W + 1;
    localparam int unsigned EXT_W    = REG_W + DATA_WIDTH_O;
    localparam int          GAIN_ADJ = int'(DATA_WIDTH_O) - int'(DATA_WIDTH_I);

    if (ORDER < ORDER_MIN || ORDER > ORDER_MAX || MAX_LOG2 < LOG2_MIN) begin : g_param_check
        $error("cic_decimator: ORDER or MAX_LOG2 outside legal range");
    end

    logic [REG_W-1:0]          integ_q [ORDER];
    logic [REG_W-1:0]          integ_d [ORDER];
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [CNT_W-1:0]          cnt_last;
    logic [LOG2_W-1:0]         active_q;
    logic [LOG2_W-1:0]         active_d;
    logic [LOG2_W-1:0]         ratio_clamped;
    logic                      frame_end;
    logic signed [SHIFT_W-1:0] shift_now;

    logic                      tok_q;
    logic [REG_W-1:0]          cap_q;
    logic signed [SHIFT_W-1:0] sh_q [ORDER+1];

    logic                      comb_v    [ORDER+1];
    logic [REG_W-1:0]          comb_data [ORDER+1];

    logic signed [EXT_W-1:0]   ext;
    logic                      sh_left;
    logic [SHIFT_W-1:0]        sh_amt;
    logic [DATA_WIDTH_O-1:0]   out_d;
    logic                      out_valid_q;
    logic [DATA_WIDTH_O-1:0]   out_data_q;

    // Integrators, sample counter and frame-boundary exponent latch.
    always_comb begin
        ratio_clamped = ratio_log2;
        if (ratio_log2 < LOG2_W'(LOG2_MIN)) begin
            ratio_clamped = LOG2_W'(LOG2_MIN);
        end else if (ratio_log2 > LOG2_W'(MAX_LOG2)) begin
            ratio_clamped = LOG2_W'(MAX_LOG2);
        end

        cnt_last  = CNT_W'((CW1'(1) << active_q) - CW1'(1));
        frame_end = in_valid && (cnt_q == cnt_last);
        shift_now = SHIFT_W'(int'(ORDER) * int'(active_q) - GAIN_ADJ);

        cnt_d    = cnt_q;
        active_d = active_q;
        integ_d  = integ_q;
        if (in_valid) begin
            cnt_d      = frame_end ? '0 : cnt_q + CNT_W'(1);
            integ_d[0] = integ_q[0] + REG_W'($signed(in_data));
            for (int unsigned k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
        if (frame_end) begin
            active_d = ratio_clamped;
        end
    end

    // The shift amount rides a plain delay line: a token advances exactly one comb stage per cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            integ_q  <= '{default: '0};
            cnt_q    <= '0;
            active_q <= LOG2_W'(DEFAULT_LOG2);
            tok_q    <= 1'b0;
            cap_q    <= '0;
            sh_q     <= '{default: '0};
        end else begin
            integ_q  <= integ_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            tok_q    <= frame_end;
            if (frame_end) begin
                cap_q   <= integ_d[ORDER-1];
                sh_q[0] <= shift_now;
            end
            for (int unsigned k = 1; k <= ORDER; k++) begin
                sh_q[k] <= sh_q[k-1];
            end
        end
    end

    assign comb_v[0]    = tok_q;
    assign comb_data[0] = cap_q;

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .REG_W (REG_W)
        ) u_stage (
            .clk     (clk),
            .arst    (arst),
            .valid_i (comb_v[g]),
            .data_i  (comb_data[g]),
            .valid_o (comb_v[g+1]),
            .data_o  (comb_data[g+1])
        );
    end

`ifdef CIC_DECIMATOR_ROUND_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-DATA_WIDTH_O+1){1'b0}}, {(DATA_WIDTH_O-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-DATA_WIDTH_O+1){1'b1}}, {(DATA_WIDTH_O-1){1'b0}}};
    logic signed [EXT_W-1:0] shifted;
`endif

    // Gain normalisation of the last comb output.
    always_comb begin
        ext     = EXT_W'($signed(comb_data[ORDER]));
        sh_left = sh_q[ORDER][SHIFT_W-1];
        sh_amt  = sh_left ? SHIFT_W'(-sh_q[ORDER]) : SHIFT_W'(sh_q[ORDER]);
`ifdef CIC_DECIMATOR_ROUND_SAT_EN
        shifted = ext;
        if (!sh_left && (sh_amt != '0)) begin
            shifted = ext + (EXT_W'(1) << (sh_amt - SHIFT_W'(1)));
        end
        shifted = sh_left ? (shifted << sh_amt) : (shifted >>> sh_amt);
        if (shifted > SAT_MAX) begin
            out_d = {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            out_d = {1'b1, {(DATA_WIDTH_O-1){1'b0}}};
        end else begin
            out_d = DATA_WIDTH_O'(shifted);
        end
`else
        out_d = sh_left ? DATA_WIDTH_O'(ext << sh_amt) : DATA_WIDTH_O'(ext >>> sh_amt);
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= comb_v[ORDER];
            if (comb_v[ORDER]) begin
                out_data_q <= out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Randomised scoreboard bench for cic_decimator; reference is a boxcar^ORDER FIR over the sample history.
module tb_cic_decimator;

    localparam int DWI   = 12;
    localparam int DWO   = 16;
    localparam int ORDER = 4;
    localparam int MAXL  = 6;
    localparam int DEFL  = 3;
    localparam int LAT   = ORDER + 2;
    localparam int H_MAX = 400;

    logic           clk = 1'b0;
    logic           arst;
    logic           in_valid;
    logic [DWI-1:0] in_data;
    logic [2:0]     ratio_log2;
    logic           out_valid;
    logic [DWO-1:0] out_data;

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ratio_log2 (ratio_log2),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    typedef struct {
        int     cyc;
        longint val;
        bit     chk;
    } exp_t;

    exp_t   sb[$];
    longint hist[$];
    longint h_tab [MAXL+1][H_MAX];
    int     h_len [MAXL+1];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int m_l, m_cnt, m_prev, m_skip;

    always @(posedge clk) cyc <= cyc + 1;

    // Impulse response of ORDER cascaded length-2^l moving sums.
    function automatic void build_h();
        longint cur [H_MAX];
        longint nxt [H_MAX];
        int len, r;
        for (int l = 1; l <= MAXL; l++) begin
            r = 1 << l;
            cur[0] = 1;
            len = 1;
            for (int o = 0; o < ORDER; o++) begin
                for (int i = 0; i < len + r - 1; i++) begin
                    nxt[i] = 0;
                    for (int j = 0; j < r; j++) begin
                        if (i - j >= 0 && i - j < len) nxt[i] += cur[i-j];
                    end
                end
                len = len + r - 1;
                for (int i = 0; i < len; i++) cur[i] = nxt[i];
            end
            for (int i = 0; i < len; i++) h_tab[l][i] = cur[i];
            h_len[l] = len;
        end
    endfunction

    function automatic int clampl(input int l);
        return (l < 1) ? 1 : ((l > MAXL) ? MAXL : l);
    endfunction

    function automatic longint scale(input longint v, input int l);
        int     s = ORDER * l - (DWO - DWI);
        longint r = v;
`ifndef CIC_DECIMATOR_ROUND_SAT_EN
        logic signed [DWO-1:0] t;
`endif
`ifdef CIC_DECIMATOR_ROUND_SAT_EN
        if (s > 0) r = r + (longint'(1) << (s - 1));
`endif
        if (s >= 0) r = r >>> s;
        else        r = r << (-s);
`ifdef CIC_DECIMATOR_ROUND_SAT_EN
        if (r > (longint'(1) << (DWO - 1)) - 1) r = (longint'(1) << (DWO - 1)) - 1;
        if (r < -(longint'(1) << (DWO - 1)))    r = -(longint'(1) << (DWO - 1));
        return r;
`else
        t = r[DWO-1:0];
        return longint'(t);
`endif
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_l    = DEFL;
        m_cnt  = 0;
        m_prev = -1;
        m_skip = 0;
    endfunction

    // Called on the accepted sample that closes a frame of length 2^m_l.
    function automatic void frame_done();
        exp_t   e;
        int     base = hist.size() - 1 - (ORDER - 1);
        longint acc  = 0;
        if (m_l != m_prev) begin
            m_skip = ORDER;
            m_prev = m_l;
        end
        for (int j = 0; j < h_len[m_l]; j++) begin
            int idx = base - j;
            if (idx >= 0) acc += h_tab[m_l][j] * hist[idx];
        end
        e.cyc = cyc + LAT;
        e.val = scale(acc, m_l);
        e.chk = (m_skip == 0);
        if (m_skip > 0) m_skip--;
        sb.push_back(e);
    endfunction

    task automatic step(input bit v, input logic [DWI-1:0] d);
        in_valid = v;
        in_data  = d;
        if (v) begin
            hist.push_back(longint'($signed(d)));
            if (m_cnt == (1 << m_l) - 1) begin
                frame_done();
                m_cnt = 0;
                m_l   = clampl(int'(ratio_log2));
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic do_reset(input int n);
        arst     = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data", longint'($signed(out_data)), 0);
        arst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every pulse and checks that out_data holds in between.
    logic [DWO-1:0] last_data = '0;
    exp_t           got;
    always @(negedge clk) begin
        if (arst) begin
            last_data <= '0;
        end else if (out_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: out_valid=1 data=%0d at cycle %0d, required no pulse",
                         $signed(out_data), cyc);
            end else begin
                got = sb.pop_front();
                if (cyc != got.cyc) begin
                    miscompares++;
                    $display("FAIL pulse_latency: pulse at cycle %0d, required cycle %0d", cyc, got.cyc);
                end
                if (got.chk) begin
                    vectors++;
                    if (longint'($signed(out_data)) != got.val) begin
                        miscompares++;
                        $display("FAIL out_data: got %0d, required %0d at cycle %0d",
                                 $signed(out_data), got.val, cyc);
                    end
                end
            end
            last_data <= out_data;
        end else begin
            vectors++;
            if (out_data !== last_data) begin
                miscompares++;
                $display("FAIL hold: out_data %0d changed without pulse, required %0d at cycle %0d",
                         $signed(out_data), $signed(last_data), cyc);
            end
        end
    end

    int n_seg;

    initial begin
        arst       = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        ratio_log2 = 3'd3;
        build_h();
        do_reset(3);

        // DC tests at ratio 8, gap-free.
        repeat (8 * 20) step(1'b1, 12'd100);
        repeat (8 * 20) step(1'b1, 12'h800);
        repeat (8 * 12) step(1'b1, 12'd100);

        // Alternating valid with random junk on idle cycles.
        repeat (8 * 12) begin
            step(1'b1, 12'd100);
            step(1'b0, DWI'($urandom));
        end

        // Exponent change 3 -> 5 in the middle of a frame.
        repeat (3) step(1'b1, 12'd100);
        ratio_log2 = 3'd5;
        repeat (32 * 9 + 5) step(1'b1, 12'd100);

        // Reset two cycles after a frame-completing sample.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 12'd100);
            if (m_cnt == 0) break;
        end
        step(1'b0, 12'd0);
        do_reset(2);
        repeat (8 * 3) step(1'b1, 12'd100);
        ratio_log2 = 3'd3;
        repeat (32 + 8 * 8) step(1'b1, 12'd100);

        // Random data, random valid, random (including illegal) exponents.
        for (int seg = 0; seg < 10; seg++) begin
            if (seg == 0)      ratio_log2 = 3'd0;
            else if (seg == 1) ratio_log2 = 3'd7;
            else               ratio_log2 = 3'($urandom_range(0, 7));
            n_seg = (1 << clampl(int'(ratio_log2))) * (ORDER + 5);
            for (int i = 0; i < n_seg; i++) begin
                step($urandom_range(0, 3) != 0, DWI'($urandom));
            end
        end

        // Drain the pipeline with a bounded wait.
        for (int i = 0; i < 200 && sb.size() != 0; i++) step(1'b0, 12'd0);
        repeat (LAT + 2) step(1'b0, 12'd0);
        check("drain_pending", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
